hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: RST  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL: ihit  in  1  instruction fetch complete this cycle.
REQ-004 SHALL: dhit  in  1  data access complete this cycle.
REQ-005 SHALL: ifid_rs, ifid_rt  in  5 each  source registers of instruction in ID.
REQ-006 SHALL: idex_mem_read  in  1; idex_rt  in  5  load and destination in EX.
REQ-007 SHALL: exmem_mem_read, exmem_mem_write  in  1 each  data request in MEM.
REQ-008 SHALL: exmem_pc_src  in  1  taken branch/jump redirect resolved in MEM.
REQ-009 SHALL: exmem_halt  in  1  halt instruction in MEM.
REQ-010 SHALL: pc_en  out  1  PC update enable.
REQ-011 SHALL: ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze, exmem_en, exmem_flush, memwb_en  out  1 each  latch controls.
REQ-012 SHALL: halted  out  1  sticky halt indication.

Function
REQ-013 SHALL: FSM states RUN, DWAIT, HALT; 2-bit state register; outputs are combinational from state and inputs.
REQ-014 SHALL: define dpend = (exmem_mem_read | exmem_mem_write) & ~dhit; advance = ihit & ~dpend.
REQ-015 SHALL: RUN, dpend=1 -> go to DWAIT; all en=0, idex_freeze=1, pc_en=0, all flush=0.
REQ-016 SHALL: DWAIT, dhit=0 -> stay; same outputs as REQ-015.
REQ-017 SHALL: DWAIT, dhit=1 -> return to RUN; evaluate outputs that cycle as RUN with dpend=0.
REQ-018 SHALL: RUN, advance=0, dpend=0 (ihit miss) -> all latches and PC frozen; no flush.
REQ-019 SHALL: RUN, advance=1, exmem_halt=1 -> go to HALT; memwb_en=1, every other en=0, pc_en=0.
REQ-020 SHALL: RUN, advance=1, exmem_pc_src=1 -> pc_en=1, all en=1, ifid_flush=idex_flush=exmem_flush=1.
REQ-021 SHALL: RUN, advance=1, load-use hazard -> pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1. Hazard = idex_mem_read & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
REQ-022 SHALL: RUN, advance=1, no other condition -> pc_en and all en=1, all flush=0, idex_freeze=0.
REQ-023 SHALL: in RUN with advance=1, priority is halt > redirect > load-use.
REQ-024 SHALL: a redirect suppresses a concurrent load-use bubble.
REQ-025 SHALL: HALT is absorbing until RST; halted=1, pc_en=0, all en=0, all flush=0; inputs are ignored.
REQ-026 SHALL: idex_rt==0 never triggers a load-use stall.

Reset
REQ-027 SHALL: while RST=1, state=RUN, halted=0, pc_en=0, all en=0, all flush=0, idex_freeze=0.
REQ-028 SHALL: RST asserted in any state, including DWAIT or HALT, immediately returns the FSM to RUN.

Configuration
REQ-029 SHALL: macro HAZARD_PERF_EN defined -> add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-030 SHALL: with HAZARD_PERF_EN, stall_cnt increments each cycle pc_en=0 in RUN/DWAIT; flush_cnt increments each redirect (REQ-020) or load-use bubble (REQ-021).
REQ-031 SHALL: with HAZARD_PERF_EN, both counters wrap modulo 2^32, reset to 0, and hold in HALT.
REQ-032 SHALL: HAZARD_PERF_EN undefined -> counters and ports are absent; all other behaviour is identical.

Verification
REQ-033 SHALL: idex_mem_read=1, idex_rt=5, ifid_rs=5, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle (idex_mem_read=0) full advance.
REQ-034 SHALL: exmem_mem_read=1, dhit=0 for 3 cycles then 1 -> state DWAIT 3 cycles, all en=0, idex_freeze=1; 4th cycle all en=1.
REQ-035 SHALL: exmem_pc_src=1 with load-use hazard present, ihit=1 -> ifid/idex/exmem_flush=1, pc_en=1, no load-use stall.
REQ-036 SHALL: exmem_halt=1, ihit=1 -> next cycle halted=1, pc_en=0; stays halted 10 cycles with random inputs; RST restores RUN.
REQ-037 SHALL: RST pulsed mid-DWAIT -> outputs immediately at REQ-027 values; after release, RUN behaviour.
REQ-038 SHALL: with HAZARD_PERF_EN, 2 load-use bubbles plus 1 redirect -> flush_cnt=3, stall_cnt=2.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller (load-use, redirect, D-miss, halt).
//            Optional HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic        exmem_mem_read,
    input  logic        exmem_mem_write,
    input  logic        exmem_pc_src,
    input  logic        exmem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        idex_freeze,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic w_dpend;
    logic w_wait;
    logic w_advance;
    logic w_load_use;

    assign w_dpend    = (exmem_mem_read | exmem_mem_write) & ~dhit;
    // Once waiting, only dhit releases the stall; the request is still held in MEM.
    assign w_wait     = (state_q == ST_DWAIT) ? ~dhit : w_dpend;
    assign w_advance  = ihit & ~w_wait;
    assign w_load_use = idex_mem_read & (idex_rt != 5'd0) &
                        ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        idex_freeze = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_RUN, ST_DWAIT: begin
                if (w_wait) begin
                    state_d     = ST_DWAIT;
                    idex_freeze = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    if (w_advance) begin
                        if (exmem_halt) begin
                            state_d  = ST_HALT;
                            memwb_en = 1'b1;
                        end else if (exmem_pc_src) begin
                            pc_en       = 1'b1;
                            ifid_en     = 1'b1;
                            idex_en     = 1'b1;
                            exmem_en    = 1'b1;
                            memwb_en    = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                        end else if (w_load_use) begin
                            idex_en    = 1'b1;
                            idex_flush = 1'b1;
                            exmem_en   = 1'b1;
                            memwb_en   = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            ifid_en  = 1'b1;
                            idex_en  = 1'b1;
                            exmem_en = 1'b1;
                            memwb_en = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset overrides everything combinationally so outputs drop immediately.
        if (rst) begin
            state_d     = ST_RUN;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            idex_freeze = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // idex_flush is asserted exactly for redirects and load-use bubbles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != ST_HALT) && !pc_en) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (idex_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard testbench for hazard_ctrl (HAZARD_PERF_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ihit, dhit;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_mem_read, exmem_mem_read, exmem_mem_write;
    logic       exmem_pc_src, exmem_halt;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze;
    logic       exmem_en, exmem_flush, memwb_en, halted;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ihit            (ihit),
        .dhit            (dhit),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .exmem_pc_src    (exmem_pc_src),
        .exmem_halt      (exmem_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .idex_freeze     (idex_freeze),
        .exmem_en        (exmem_en),
        .exmem_flush     (exmem_flush),
        .memwb_en        (memwb_en),
        .halted          (halted)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze, exmem_en, exmem_flush, memwb_en}
    localparam logic [9:0] c_zero   = 10'b00_0000_0000;
    localparam logic [9:0] c_all    = 10'b01_1010_0101;
    localparam logic [9:0] c_redir  = 10'b01_1111_0111;
    localparam logic [9:0] c_lu     = 10'b00_0011_0101;
    localparam logic [9:0] c_freeze = 10'b00_0000_1000;
    localparam logic [9:0] c_memwb  = 10'b00_0000_0001;
    localparam logic [9:0] c_halt   = 10'b10_0000_0000;

    logic [9:0] w_obs;
    assign w_obs = {halted, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    idex_freeze, exmem_en, exmem_flush, memwb_en};

    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         m_st  = 0;   // 0 RUN, 1 DWAIT, 2 HALT

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference built straight from the priority table.
    task automatic model(output logic [9:0] o, output int nst);
        logic lu;
        lu  = idex_mem_read && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        o   = c_zero;
        nst = m_st;
        if (m_st == 2) begin
            o = c_halt;
        end else if ((m_st == 1 && !dhit) ||
                     (m_st == 0 && (exmem_mem_read || exmem_mem_write) && !dhit)) begin
            o   = c_freeze;
            nst = 1;
        end else begin
            nst = 0;
            if (!ihit)             o = c_zero;
            else if (exmem_halt) begin o = c_memwb; nst = 2; end
            else if (exmem_pc_src) o = c_redir;
            else if (lu)           o = c_lu;
            else                   o = c_all;
        end
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic mr, input logic mw,
                          input logic ps, input logic hl, input logic idmr,
                          input logic [4:0] rtx, input logic [4:0] rs, input logic [4:0] rt);
        ihit = ih; dhit = dh; exmem_mem_read = mr; exmem_mem_write = mw;
        exmem_pc_src = ps; exmem_halt = hl; idex_mem_read = idmr;
        idex_rt = rtx; ifid_rs = rs; ifid_rt = rt;
    endtask

    task automatic pop_cmp(input string tag);
        if (exp_q.size() == 0) check({tag, "_empty"}, 32'd1, 32'd0);
        else                   check(tag, {22'd0, w_obs}, {22'd0, exp_q.pop_front()});
    endtask

    // One cycle: drive after the edge, predict, compare mid-cycle, commit model state.
    task automatic step(input string tag, input logic ih, input logic dh, input logic mr,
                        input logic mw, input logic ps, input logic hl, input logic idmr,
                        input logic [4:0] rtx, input logic [4:0] rs, input logic [4:0] rt);
        logic [9:0] e;
        int         nst;
        @(posedge clk);
        #1;
        set_in(ih, dh, mr, mw, ps, hl, idmr, rtx, rs, rt);
        model(e, nst);
        exp_q.push_back(e);
        #3;
        pop_cmp(tag);
        m_st = nst;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(c_zero);
        #1;
        pop_cmp(tag);
        m_st = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset("reset");

        step("adv",        1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("lu_rs",      1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd7);
        step("lu_after",   1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd7);
        step("lu_rt",      1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9);
        step("lu_nomatch", 1, 0, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd4);
        step("lu_r0",      1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step("imiss",      0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("imiss_lu",   0, 0, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0);

        for (int i = 0; i < 3; i++)
            step("dmiss",  1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("dhit_rel",   1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("wr_hit",     1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("wr_miss",    1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("dwait_imis", 0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        step("redir_lu",   1, 0, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0);
        step("halt",       1, 0, 0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0);
        for (int i = 0; i < 10; i++)
            step("halt_hold", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom));
        do_reset("halt_rst");
        step("post_halt",  1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        step("dw_enter",   1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("dw_stay",    1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        do_reset("dw_rst");
        step("dw_postrst", 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        do_reset("perf_rst");
        step("p_lu1",      1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
        step("p_adv1",     1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("p_lu2",      1, 0, 0, 0, 0, 0, 1, 5'd6, 5'd0, 5'd6);
        step("p_redir",    1, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("p_adv2",     1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
`ifdef HAZARD_PERF_EN
        check("flush_cnt", flush_cnt, 32'd3);
        check("stall_cnt", stall_cnt, 32'd2);
        step("p_halt",     1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++)
            step("p_halted", 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        check("stall_hold", stall_cnt, 32'd3);
        check("flush_hold", flush_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
